alu16_chk: RTL and testbench
============================

ALU16_CHK -- requirements
Module: alu16_chk

Interface
REQ-001 Parameter CNT_W, default 16, width of sample/error counters.
REQ-002 Parameter LAT, default 0, cycles between a sample handshake and its DUT result being valid on dut_out/dut_ov (0..3).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  pulse; IDLE/DONE -> RUN, clears counters.
REQ-006 stop  input  1  pulse; RUN -> DRAIN.
REQ-007 in_valid  input  1  operand sample valid.
REQ-008 in_ready  output  1  checker accepts a sample this cycle.
REQ-009 ina, inb  input  16 each  operands applied to the DUT ALU.
REQ-010 sel  input  2  opcode: 00 ADD, 01 SUB (ina-inb), 10 AND, 11 OR.
REQ-011 dut_out  input  16  DUT result; dut_ov  input  1  DUT overflow.
REQ-012 busy  output  1  state is RUN or DRAIN.
REQ-013 done  output  1  state is DONE.
REQ-014 smp_cnt, err_cnt  output  CNT_W each  samples compared / mismatches.
REQ-015 err_flag  output  1  sticky, set on first mismatch since start.
REQ-016 log_sel 2, log_a 16, log_b 16, log_got 16, log_exp 16, log_ov_got 1, log_ov_exp 1  outputs  first-mismatch record.

Function
REQ-017 FSM states IDLE, RUN, DRAIN, DONE; reset to IDLE.
REQ-018 IDLE/DONE + start -> RUN; RUN + stop -> DRAIN; DRAIN + pipeline empty -> DONE; start in RUN/DRAIN ignored.
REQ-019 in_ready = 1 only in RUN; a sample is accepted when in_valid && in_ready.
REQ-020 Accepted ina/inb/sel enter a delay line of depth LAT+1; compare stage samples dut_out/dut_ov exactly LAT cycles after handshake.
REQ-021 Expected: ADD = (ina+inb)[15:0], ov = signed overflow (operand signs equal, result sign differs); SUB = (ina-inb)[15:0], ov = operand signs differ and result sign differs from ina; AND/OR bitwise, ov = 0.
REQ-022 Mismatch = result or ov differs; compare registered, counters update one cycle after sampling.
REQ-023 smp_cnt increments per compare, err_cnt per mismatch; both saturate at 2^CNT_W-1, no wrap.
REQ-024 stop in same cycle as a handshake: sample is accepted and checked before DONE.
REQ-025 start in DONE clears counters, err_flag and log outputs in the same edge as entering RUN.
REQ-026 Samples in flight on DRAIN still compared; DRAIN lasts exactly until the delay line and compare stage are empty.

Reset
REQ-027 rst_n low: state IDLE, in_ready 0, busy 0, done 0, counters 0, err_flag 0, delay line invalid, all log outputs 0.
REQ-028 Reset mid-RUN discards in-flight samples; no count change after reset release without a new start.

Configuration
REQ-029 ALU16_CHK_LOG_EN defined: first mismatch after start captures sel, ina, inb, dut_out, expected result, dut_ov, expected ov into log_*, held until next start or reset.
REQ-030 ALU16_CHK_LOG_EN undefined: log_* ports present, tied to 0; counters and err_flag unaffected.

Structure
REQ-031 Shared package alu16_pkg holds opcode constants (OP_ADD, OP_SUB, OP_AND, OP_OR), data width 16, FSM state encoding.
REQ-032 Sub-module alu16_ref: combinational golden model (ina, inb, sel -> exp_out, exp_ov), reusable by other benches.

Verification
REQ-033 LAT=0, start, ADD 0x7FFF+0x0001, DUT 0x8000 ov=1 -> smp_cnt 1, err_cnt 0, err_flag 0.
REQ-034 SUB 0x8000-0x0001, DUT 0x7FFF ov=0 -> err_cnt 1, err_flag 1, log_ov_exp 1, log_ov_got 0 (LOG_EN).
REQ-035 LAT=2, 8 back-to-back AND/OR samples, DUT correct, stop on last handshake -> DONE after drain, smp_cnt 8, err_cnt 0.
REQ-036 CNT_W=2, 5 mismatching samples -> err_cnt saturates at 3, smp_cnt 3.
REQ-037 rst_n low mid-RUN with 2 samples in flight -> IDLE, counters 0, no compare after release; start resumes cleanly.
REQ-038 in_valid high in IDLE/DRAIN -> in_ready 0, smp_cnt unchanged.

Source files
------------

// File: rtl/alu16_pkg.sv
// Shared definitions for the ALU16 checker: data width, opcodes,
// checker FSM encoding and the delay-line sample record.
package alu16_pkg;

  localparam int DW = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // One accepted operand sample travelling towards the compare stage.
  typedef struct packed {
    logic          v;
    logic [1:0]    sel;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } smp_t;

endpackage

// File: rtl/alu16_ref.sv
// Combinational golden model of the 16-bit ALU: result and signed overflow.
module alu16_ref
  import alu16_pkg::*;
(
  input  logic [DW-1:0] ina,
  input  logic [DW-1:0] inb,
  input  logic [1:0]    sel,
  output logic [DW-1:0] exp_out,
  output logic          exp_ov
);

  logic [DW-1:0] sum_s;
  logic [DW-1:0] dif_s;

  assign sum_s = ina + inb;
  assign dif_s = ina - inb;

  // Opcode decode; overflow only meaningful for the arithmetic ops.
  always_comb begin
    exp_out = {DW{1'b0}};
    exp_ov  = 1'b0;
    case (sel)
      OP_ADD: begin
        exp_out = sum_s;
        exp_ov  = (ina[DW-1] == inb[DW-1]) && (sum_s[DW-1] != ina[DW-1]);
      end
      OP_SUB: begin
        exp_out = dif_s;
        exp_ov  = (ina[DW-1] != inb[DW-1]) && (dif_s[DW-1] != ina[DW-1]);
      end
      OP_AND: begin
        exp_out = ina & inb;
        exp_ov  = 1'b0;
      end
      OP_OR: begin
        exp_out = ina | inb;
        exp_ov  = 1'b0;
      end
      default: begin
        exp_out = {DW{1'b0}};
        exp_ov  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu16_chk.sv
// Run-time checker for a 16-bit ALU. Accepted operand samples travel down a
// delay line of depth LAT+1; the DUT result is captured in the same edge the
// sample reaches the last stage, and counters update one edge later.
// Optional first-mismatch log: define ALU16_CHK_LOG_EN to enable it,
// otherwise the log_* ports are tied to zero.
module alu16_chk
  import alu16_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int LAT   = 0
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    ina,
  input  logic [DW-1:0]    inb,
  input  logic [1:0]       sel,
  input  logic [DW-1:0]    dut_out,
  input  logic             dut_ov,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  output logic [1:0]       log_sel,
  output logic [DW-1:0]    log_a,
  output logic [DW-1:0]    log_b,
  output logic [DW-1:0]    log_got,
  output logic [DW-1:0]    log_exp,
  output logic             log_ov_got,
  output logic             log_ov_exp
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             done_r;
  smp_t             dl_r [0:LAT];
  smp_t             cmp_s;
  logic [DW-1:0]    got_r;
  logic             got_ov_r;
  logic [DW-1:0]    exp_out_s;
  logic             exp_ov_s;
  logic             hs_s;
  logic             clr_s;
  logic             mis_s;
  logic             line_busy_s;
  logic [CNT_W-1:0] smp_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic             err_flag_r;

  assign hs_s  = in_valid & in_ready_r;
  assign clr_s = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign cmp_s = dl_r[LAT];

  // Pipeline occupancy, including the compare stage, gates DRAIN -> DONE.
  always_comb begin
    line_busy_s = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      line_busy_s = line_busy_s | dl_r[k].v;
    end
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r    <= ST_RUN;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_r    <= ST_DRAIN;
            in_ready_r <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!line_busy_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  // Operand delay line plus DUT result capture aligned with its last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LAT; k++) begin
        dl_r[k] <= {$bits(smp_t){1'b0}};
      end
      got_r    <= {DW{1'b0}};
      got_ov_r <= 1'b0;
    end else begin
      dl_r[0] <= {hs_s, sel, ina, inb};
      for (int k = 1; k <= LAT; k++) begin
        dl_r[k] <= dl_r[k-1];
      end
      got_r    <= dut_out;
      got_ov_r <= dut_ov;
    end
  end

  alu16_ref u_ref (
    .ina     (cmp_s.a),
    .inb     (cmp_s.b),
    .sel     (cmp_s.sel),
    .exp_out (exp_out_s),
    .exp_ov  (exp_ov_s)
  );

  assign mis_s = cmp_s.v & ((got_r != exp_out_s) | (got_ov_r != exp_ov_s));

  // Saturating sample/error counters and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt_r  <= {CNT_W{1'b0}};
      err_cnt_r  <= {CNT_W{1'b0}};
      err_flag_r <= 1'b0;
    end else if (clr_s) begin
      smp_cnt_r  <= {CNT_W{1'b0}};
      err_cnt_r  <= {CNT_W{1'b0}};
      err_flag_r <= 1'b0;
    end else begin
      if (cmp_s.v && (smp_cnt_r != CNT_MAX)) begin
        smp_cnt_r <= smp_cnt_r + CNT_ONE;
      end
      if (mis_s && (err_cnt_r != CNT_MAX)) begin
        err_cnt_r <= err_cnt_r + CNT_ONE;
      end
      if (mis_s) begin
        err_flag_r <= 1'b1;
      end
    end
  end

  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign smp_cnt  = smp_cnt_r;
  assign err_cnt  = err_cnt_r;
  assign err_flag = err_flag_r;

`ifdef ALU16_CHK_LOG_EN
  logic [1:0]    log_sel_r;
  logic [DW-1:0] log_a_r;
  logic [DW-1:0] log_b_r;
  logic [DW-1:0] log_got_r;
  logic [DW-1:0] log_exp_r;
  logic          log_ov_got_r;
  logic          log_ov_exp_r;

  // Capture the first mismatch after start; err_flag_r marks "already taken".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_sel_r    <= 2'b00;
      log_a_r      <= {DW{1'b0}};
      log_b_r      <= {DW{1'b0}};
      log_got_r    <= {DW{1'b0}};
      log_exp_r    <= {DW{1'b0}};
      log_ov_got_r <= 1'b0;
      log_ov_exp_r <= 1'b0;
    end else if (clr_s) begin
      log_sel_r    <= 2'b00;
      log_a_r      <= {DW{1'b0}};
      log_b_r      <= {DW{1'b0}};
      log_got_r    <= {DW{1'b0}};
      log_exp_r    <= {DW{1'b0}};
      log_ov_got_r <= 1'b0;
      log_ov_exp_r <= 1'b0;
    end else if (mis_s && !err_flag_r) begin
      log_sel_r    <= cmp_s.sel;
      log_a_r      <= cmp_s.a;
      log_b_r      <= cmp_s.b;
      log_got_r    <= got_r;
      log_exp_r    <= exp_out_s;
      log_ov_got_r <= got_ov_r;
      log_ov_exp_r <= exp_ov_s;
    end
  end

  assign log_sel    = log_sel_r;
  assign log_a      = log_a_r;
  assign log_b      = log_b_r;
  assign log_got    = log_got_r;
  assign log_exp    = log_exp_r;
  assign log_ov_got = log_ov_got_r;
  assign log_ov_exp = log_ov_exp_r;
`else
  assign log_sel    = 2'b00;
  assign log_a      = {DW{1'b0}};
  assign log_b      = {DW{1'b0}};
  assign log_got    = {DW{1'b0}};
  assign log_exp    = {DW{1'b0}};
  assign log_ov_got = 1'b0;
  assign log_ov_exp = 1'b0;
`endif

endmodule

// File: tb/tb_alu16_chk.sv
// Scoreboard bench for alu16_chk: two instances (LAT=0/CNT_W=2 and
// LAT=2/CNT_W=16). Expected end-of-run results are queued when a run is
// issued and compared by a monitor when the instance raises done.
module tb_alu16_chk;
  import alu16_pkg::*;

`ifdef ALU16_CHK_LOG_EN
  localparam bit LOG_ON = 1'b1;
`else
  localparam bit LOG_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] smp;
    logic [31:0] err;
    logic        flag;
    logic [1:0]  lsel;
    logic [15:0] la;
    logic [15:0] lb;
    logic [15:0] lgot;
    logic [15:0] lexp;
    logic        lovg;
    logic        love;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, stop = 1'b0, in_valid = 1'b0;
  logic [15:0] ina = 16'h0, inb = 16'h0;
  logic [1:0]  sel = 2'b00;
  logic [15:0] dut_out0 = 16'h0;
  logic        dut_ov0 = 1'b0;
  logic [15:0] nxt_out1 = 16'h0;
  logic        nxt_ov1 = 1'b0;
  logic [15:0] p1_out [0:1];
  logic        p1_ov  [0:1];
  logic [15:0] dut_out1;
  logic        dut_ov1;

  logic        d0_rdy, d0_busy, d0_done, d0_flag, d0_lovg, d0_love;
  logic [1:0]  d0_smp, d0_err, d0_lsel;
  logic [15:0] d0_la, d0_lb, d0_lgot, d0_lexp;
  logic        d1_rdy, d1_busy, d1_done, d1_flag, d1_lovg, d1_love;
  logic [15:0] d1_smp, d1_err;
  logic [1:0]  d1_lsel;
  logic [15:0] d1_la, d1_lb, d1_lgot, d1_lexp;

  int total = 0;
  int bad = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic [1:0]  v_sel [0:7] = '{OP_AND, OP_OR, OP_AND, OP_OR, OP_AND, OP_OR, OP_AND, OP_OR};
  logic [15:0] v_a   [0:7] = '{16'hFFFF, 16'h1234, 16'hAAAA, 16'hAAAA, 16'hF0F0, 16'h0F0F, 16'h8001, 16'h0000};
  logic [15:0] v_b   [0:7] = '{16'h00FF, 16'h4321, 16'h5555, 16'h5555, 16'hFF00, 16'h00F0, 16'h8000, 16'h0000};
  logic [15:0] v_r   [0:7] = '{16'h00FF, 16'h5335, 16'h0000, 16'hFFFF, 16'hF000, 16'h0FFF, 16'h8000, 16'h0000};

  always #5 clk = ~clk;

  // Bench-side DUT result pipe for the LAT=2 instance.
  always @(posedge clk) begin
    p1_out[0] <= nxt_out1;
    p1_out[1] <= p1_out[0];
    p1_ov[0]  <= nxt_ov1;
    p1_ov[1]  <= p1_ov[0];
  end
  assign dut_out1 = p1_out[1];
  assign dut_ov1  = p1_ov[1];

  alu16_chk #(.CNT_W(2), .LAT(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop), .in_valid(in_valid),
    .in_ready(d0_rdy), .ina(ina), .inb(inb), .sel(sel), .dut_out(dut_out0), .dut_ov(dut_ov0),
    .busy(d0_busy), .done(d0_done), .smp_cnt(d0_smp), .err_cnt(d0_err), .err_flag(d0_flag),
    .log_sel(d0_lsel), .log_a(d0_la), .log_b(d0_lb), .log_got(d0_lgot), .log_exp(d0_lexp),
    .log_ov_got(d0_lovg), .log_ov_exp(d0_love)
  );

  alu16_chk #(.CNT_W(16), .LAT(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop), .in_valid(in_valid),
    .in_ready(d1_rdy), .ina(ina), .inb(inb), .sel(sel), .dut_out(dut_out1), .dut_ov(dut_ov1),
    .busy(d1_busy), .done(d1_done), .smp_cnt(d1_smp), .err_cnt(d1_err), .err_flag(d1_flag),
    .log_sel(d1_lsel), .log_a(d1_la), .log_b(d1_lb), .log_got(d1_lgot), .log_exp(d1_lexp),
    .log_ov_got(d1_lovg), .log_ov_exp(d1_love)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", nm, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] smp, input logic [31:0] err, input logic flag,
                              input logic [1:0] ls, input logic [15:0] la, input logic [15:0] lb,
                              input logic [15:0] lg, input logic [15:0] le,
                              input logic lovg, input logic love);
    exp_t e;
    e.smp  = smp;
    e.err  = err;
    e.flag = flag;
    e.lsel = LOG_ON ? ls : 2'b00;
    e.la   = LOG_ON ? la : 16'h0;
    e.lb   = LOG_ON ? lb : 16'h0;
    e.lgot = LOG_ON ? lg : 16'h0;
    e.lexp = LOG_ON ? le : 16'h0;
    e.lovg = LOG_ON ? lovg : 1'b0;
    e.love = LOG_ON ? love : 1'b0;
    return e;
  endfunction

  function automatic exp_t act0();
    return '{32'(d0_smp), 32'(d0_err), d0_flag, d0_lsel, d0_la, d0_lb, d0_lgot, d0_lexp, d0_lovg, d0_love};
  endfunction

  function automatic exp_t act1();
    return '{32'(d1_smp), 32'(d1_err), d1_flag, d1_lsel, d1_la, d1_lb, d1_lgot, d1_lexp, d1_lovg, d1_love};
  endfunction

  task automatic cmp_res(input string tag, input exp_t e, input exp_t a);
    chk({tag, ".smp_cnt"},    a.smp,          e.smp);
    chk({tag, ".err_cnt"},    a.err,          e.err);
    chk({tag, ".err_flag"},   32'(a.flag),    32'(e.flag));
    chk({tag, ".log_sel"},    32'(a.lsel),    32'(e.lsel));
    chk({tag, ".log_a"},      32'(a.la),      32'(e.la));
    chk({tag, ".log_b"},      32'(a.lb),      32'(e.lb));
    chk({tag, ".log_got"},    32'(a.lgot),    32'(e.lgot));
    chk({tag, ".log_exp"},    32'(a.lexp),    32'(e.lexp));
    chk({tag, ".log_ov_got"}, 32'(a.lovg),    32'(e.lovg));
    chk({tag, ".log_ov_exp"}, 32'(a.love),    32'(e.love));
  endtask

  // Drive one sample for one cycle; both instances see the same operands.
  task automatic send(input logic [1:0] s, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] g, input logic gov, input logic stp);
    in_valid = 1'b1; sel = s; ina = a; inb = b;
    dut_out0 = g; dut_ov0 = gov; nxt_out1 = g; nxt_ov1 = gov; stop = stp;
    cyc();
    in_valid = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int maxc);
    int n;
    n = 0;
    while ((((idx == 0) ? d0_done : d1_done) == 1'b0) && (n < maxc)) begin
      cyc();
      n++;
    end
    chk((idx == 0) ? "d0.done_reached" : "d1.done_reached",
        32'((idx == 0) ? d0_done : d1_done), 32'd1);
  endtask

  // Monitor: pop and compare an expected result whenever an instance raises done.
  initial begin
    logic d0q, d1q;
    exp_t e;
    d0q = 1'b0;
    d1q = 1'b0;
    forever begin
      @(negedge clk);
      if (d0_done && !d0q) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL d0.unexpected_done: got=done with empty queue required=no done");
        end else begin
          e = q0.pop_front();
          cmp_res("d0", e, act0());
        end
      end
      if (d1_done && !d1q) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL d1.unexpected_done: got=done with empty queue required=no done");
        end else begin
          e = q1.pop_front();
          cmp_res("d1", e, act1());
        end
      end
      d0q = d0_done;
      d1q = d1_done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, checked while reset is held.
    #1;
    chk("rst.d0_in_ready", 32'(d0_rdy), 32'd0);
    chk("rst.d0_busy",     32'(d0_busy), 32'd0);
    chk("rst.d0_done",     32'(d0_done), 32'd0);
    chk("rst.d0_smp_cnt",  32'(d0_smp), 32'd0);
    chk("rst.d0_err_flag", 32'(d0_flag), 32'd0);
    chk("rst.d1_log_got",  32'(d1_lgot), 32'd0);
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // in_valid while IDLE is not accepted.
    in_valid = 1'b1; ina = 16'h0001; inb = 16'h0001; sel = OP_ADD;
    cyc(); cyc();
    chk("idle.d0_in_ready", 32'(d0_rdy), 32'd0);
    chk("idle.d0_smp_cnt",  32'(d0_smp), 32'd0);
    in_valid = 1'b0;
    cyc();

    // LAT=0: correct ADD overflow, then SUB with wrong ov, stop on last handshake.
    start0 = 1'b1; cyc(); start0 = 1'b0;
    chk("a.d0_in_ready", 32'(d0_rdy), 32'd1);
    chk("a.d0_busy",     32'(d0_busy), 32'd1);
    q0.push_back(mk(32'd2, 32'd1, 1'b1, OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1));
    send(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0);
    send(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    chk("a.first_smp_cnt",  32'(d0_smp), 32'd1);
    chk("a.first_err_cnt",  32'(d0_err), 32'd0);
    chk("a.first_err_flag", 32'(d0_flag), 32'd0);
    chk("a.drain_in_ready", 32'(d0_rdy), 32'd0);
    // Offer a bad sample during DRAIN; it must be ignored.
    in_valid = 1'b1; sel = OP_ADD; ina = 16'h0001; inb = 16'h0001; dut_out0 = 16'h0000; dut_ov0 = 1'b0;
    wait_done(0, 20);
    chk("a.done_in_ready", 32'(d0_rdy), 32'd0);
    chk("a.done_busy",     32'(d0_busy), 32'd0);
    in_valid = 1'b0;
    cyc();

    // Restart from DONE clears everything; 5 mismatches saturate 2-bit counters.
    start0 = 1'b1; cyc(); start0 = 1'b0;
    chk("b.clr_smp_cnt",  32'(d0_smp), 32'd0);
    chk("b.clr_err_cnt",  32'(d0_err), 32'd0);
    chk("b.clr_err_flag", 32'(d0_flag), 32'd0);
    chk("b.clr_log_a",    32'(d0_la), 32'd0);
    chk("b.clr_done",     32'(d0_done), 32'd0);
    q0.push_back(mk(32'd3, 32'd3, 1'b1, OP_ADD, 16'h0001, 16'h0001, 16'h0003, 16'h0002, 1'b0, 1'b0));
    send(OP_ADD, 16'h0001, 16'h0001, 16'h0003, 1'b0, 1'b0);
    send(OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F1, 1'b0, 1'b0);
    send(OP_OR,  16'h1200, 16'h0034, 16'h1235, 1'b0, 1'b0);
    send(OP_SUB, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0);
    send(OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1);
    wait_done(0, 20);
    cyc();

    // LAT=2: 8 back-to-back correct AND/OR samples, stop on the last.
    start1 = 1'b1; cyc(); start1 = 1'b0;
    chk("c.d1_in_ready", 32'(d1_rdy), 32'd1);
    q1.push_back(mk(32'd8, 32'd0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      send(v_sel[i], v_a[i], v_b[i], v_r[i], 1'b0, (i == 7));
    end
    chk("c.drain_busy", 32'(d1_busy), 32'd1);
    chk("c.drain_done", 32'(d1_done), 32'd0);
    wait_done(1, 30);
    cyc();

    // Reset with two samples in flight; nothing counted after release.
    start1 = 1'b1; cyc(); start1 = 1'b0;
    send(OP_OR,  16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0);
    send(OP_AND, 16'h00FF, 16'h0F0F, 16'h1111, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("d.rst_busy",     32'(d1_busy), 32'd0);
    chk("d.rst_in_ready", 32'(d1_rdy), 32'd0);
    chk("d.rst_smp_cnt",  32'(d1_smp), 32'd0);
    chk("d.rst_err_cnt",  32'(d1_err), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("d.post_smp_cnt",  32'(d1_smp), 32'd0);
    chk("d.post_err_cnt",  32'(d1_err), 32'd0);
    chk("d.post_err_flag", 32'(d1_flag), 32'd0);
    chk("d.post_busy",     32'(d1_busy), 32'd0);
    start1 = 1'b1; cyc(); start1 = 1'b0;
    q1.push_back(mk(32'd1, 32'd0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0));
    send(OP_SUB, 16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b1);
    wait_done(1, 20);
    repeat (2) cyc();

    chk("q0.drained", 32'(q0.size()), 32'd0);
    chk("q1.drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
